// File: rtl/mino_vote_ctrl.sv
// mino_vote_ctrl
// Collects one vote bit from each of three redundant voters, waits a bounded
// number of cycles for stragglers, and reports the minority of the three
// votes on a valid/ready result port. Also counts rounds in which the votes
// that actually arrived disagreed.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Valid may rise at any time and must not depend on ready.
// Ready depends only on controller state, never on the same-cycle valid.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   v_valid[2:0]   voter i presents a vote
//   v_bit[2:0]     vote values, sampled on v_valid[i] & v_ready[i]
//   v_ready[2:0]   controller accepts voter i this cycle
//   res_valid      result available (HOLD)
//   res_ready      consumer takes the result
//   res_out        minority of the latched votes
//   res_timeout    at least one vote was forced to 0 by the timeout
//   clr_cnt        synchronous clear of mismatch_cnt (wins over increment)
//   mismatch_cnt   saturating count of rounds with disagreeing received votes
//   dbg_state      current FSM state, for checkers

module mino_vote_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       v_valid,
  input  logic [2:0]       v_bit,
  output logic [2:0]       v_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_out,
  output logic             res_timeout,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EVAL    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic [2:0] got_q, got_d;
  logic [2:0] vote_q, vote_d;
  logic [7:0] timer_q, timer_d;
  logic       tflag_q, tflag_d;

  logic [2:0] acc;
  logic [2:0] got_acc;
  logic [2:0] vote_acc;
  logic       majority;
  logic       mismatch;

  assign v_ready   = (state_q == S_IDLE || state_q == S_COLLECT) ? ~got_q : 3'b000;
  assign res_valid = (state_q == S_HOLD);
  assign dbg_state = state_q;

  assign acc      = v_valid & v_ready;
  assign got_acc  = got_q | acc;
  assign vote_acc = (acc & v_bit) | (~acc & vote_q);

  // Missing votes are already 0 in vote_q after a timeout, so the majority
  // can use vote_q directly; mismatch only looks at votes that arrived.
  assign majority = (vote_q[0] & vote_q[1]) | (vote_q[1] & vote_q[2]) |
                    (vote_q[2] & vote_q[0]);
  assign mismatch = (|(got_q & vote_q)) & (|(got_q & ~vote_q));

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    vote_d  = vote_q;
    timer_d = timer_q;
    tflag_d = tflag_q;
    case (state_q)
      S_IDLE: begin
        got_d  = got_acc;
        vote_d = vote_acc;
        if (got_acc == 3'b111) begin
          state_d = S_EVAL;
        end else if (|acc) begin
          state_d = S_COLLECT;
          timer_d = 8'd0;
        end
      end
      S_COLLECT: begin
        got_d   = got_acc;
        vote_d  = vote_acc;
        timer_d = timer_q + 8'd1;
        // A complete set wins over a timeout in the same cycle.
        if (got_acc == 3'b111) begin
          state_d = S_EVAL;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_EVAL;
          tflag_d = 1'b1;
          vote_d  = vote_acc & got_acc;
        end
      end
      S_EVAL: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
          got_d   = 3'b000;
          timer_d = 8'd0;
          tflag_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      got_q   <= 3'b000;
      vote_q  <= 3'b000;
      timer_q <= 8'd0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      vote_q  <= vote_d;
      timer_q <= timer_d;
      tflag_q <= tflag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out     <= 1'b0;
      res_timeout <= 1'b0;
    end else if (state_q == S_EVAL) begin
      res_out     <= ~majority;
      res_timeout <= tflag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (clr_cnt) begin
      mismatch_cnt <= '0;
    end else if (state_q == S_EVAL && mismatch && mismatch_cnt != CNT_MAX) begin
      mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mino_vote_ctrl.sv
module tb_mino_vote_ctrl;

  localparam int TIMEOUT = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [2:0]       v_valid;
  logic [2:0]       v_bit;
  logic [2:0]       v_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_out;
  logic             res_timeout;
  logic             clr_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [1:0]       dbg_state;

  mino_vote_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_valid     (v_valid),
    .v_bit       (v_bit),
    .v_ready     (v_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_out     (res_out),
    .res_timeout (res_timeout),
    .clr_cnt     (clr_cnt),
    .mismatch_cnt(mismatch_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_tests;
  int         n_fail;
  int         exp_cnt;
  logic [1:0] exp_q[$];   // {timeout, res_out} per round

  // Round description: which voters vote, when (cycle offset from the first
  // IDLE cycle of the round), with what value, and how long the consumer stalls.
  bit pres[3];
  int dly[3];
  bit vb[3];
  int hold_cyc;
  int clr_mode;   // 0 never, 1 random, 2 exactly in the EVAL cycle

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_v_ready", v_ready, 3'b111);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_out", res_out, 1'b0);
    check("rst_res_timeout", res_timeout, 1'b0);
    check("rst_mismatch_cnt", mismatch_cnt, 0);
  endtask

  // ---------------- driver + reference model for one round ----------------
  task automatic run_round();
    int         t0, e, last;
    bit         acc[3];
    bit         all_acc, tmo, r1, r0, mism, res, clr;
    bit         vv[3];
    logic [2:0] exp_rdy;
    logic [1:0] cur;

    // Model: the round opens at the earliest arrival; anyone arriving within
    // TIMEOUT cycles of it (inclusive) is accepted.
    t0 = 1000;
    for (int i = 0; i < 3; i++) if (pres[i] && dly[i] < t0) t0 = dly[i];
    all_acc = 1'b1;
    last    = t0;
    for (int i = 0; i < 3; i++) begin
      acc[i] = pres[i] && (dly[i] <= t0 + TIMEOUT);
      if (!acc[i]) all_acc = 1'b0;
      else if (dly[i] > last) last = dly[i];
    end
    if (all_acc) begin
      e   = last + 1;
      tmo = 1'b0;
    end else begin
      e   = t0 + TIMEOUT + 1;
      tmo = 1'b1;
    end
    r1 = 1'b0;
    r0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vv[i] = acc[i] & vb[i];
      if (acc[i] && vb[i])  r1 = 1'b1;
      if (acc[i] && !vb[i]) r0 = 1'b1;
    end
    mism = r1 && r0;
    res  = ((vv[0] ? 1 : 0) + (vv[1] ? 1 : 0) + (vv[2] ? 1 : 0)) < 2;
    exp_q.push_back({tmo, res});
    cur = 2'b00;

    for (int k = 0; k <= e + 1 + hold_cyc; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) exp_rdy[i] = (k < e) && !(acc[i] && dly[i] < k);
      check("v_ready", v_ready, exp_rdy);
      check("res_valid", res_valid, (k >= e + 1));
      if (k == e + 1) cur = exp_q.pop_front();
      if (k >= e + 1) begin
        check("res_out", res_out, cur[0]);
        check("res_timeout", res_timeout, cur[1]);
      end
      check("mismatch_cnt", mismatch_cnt, exp_cnt);

      // Voters hold valid from their arrival onward; the bit is only
      // meaningful in the arrival cycle and is scrambled afterwards.
      for (int i = 0; i < 3; i++) begin
        v_valid[i] = pres[i] && (k >= dly[i]);
        v_bit[i]   = (k == dly[i]) ? vb[i] : 1'($urandom_range(0, 1));
      end
      res_ready = (k == e + 1 + hold_cyc) || ((k <= e) && ($urandom_range(0, 1) == 1));
      case (clr_mode)
        1:       clr = ($urandom_range(0, 7) == 0);
        2:       clr = (k == e);
        default: clr = 1'b0;
      endcase
      clr_cnt = clr;

      if (clr) exp_cnt = 0;
      else if (k == e && mism && exp_cnt < CNT_MAX) exp_cnt++;
    end
  endtask

  task automatic set_round(input bit p0, input bit p1, input bit p2,
                           input int d0, input int d1, input int d2,
                           input bit b0, input bit b1, input bit b2,
                           input int h, input int cm);
    pres[0] = p0; pres[1] = p1; pres[2] = p2;
    dly[0]  = d0; dly[1]  = d1; dly[2]  = d2;
    vb[0]   = b0; vb[1]   = b1; vb[2]   = b2;
    hold_cyc = h;
    clr_mode = cm;
  endtask

  task automatic random_round();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pres[i] = ($urandom_range(0, 3) != 0);
      dly[i]  = $urandom_range(0, TIMEOUT + 4);
      vb[i]   = 1'($urandom_range(0, 1));
      if (pres[i]) any = 1'b1;
    end
    if (!any) pres[$urandom_range(0, 2)] = 1'b1;
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < 3; i++) begin
        pres[i] = 1'b1;
        dly[i]  = dly[0];
      end
    end
    hold_cyc = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 2);
    clr_mode = 1;
  endtask

  // Partial round (voters 0 and 2 accepted, in COLLECT), then an
  // asynchronous reset between clock edges.
  task automatic reset_mid_collect();
    @(negedge clk);
    check("pre_rst_v_ready_idle", v_ready, 3'b111);
    v_valid = 3'b101;
    v_bit   = 3'($urandom_range(0, 7));
    clr_cnt = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_v_ready_collect", v_ready, 3'b010);
    v_valid = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    v_valid   = 3'b000;
    v_bit     = 3'b000;
    res_ready = 1'b0;
    clr_cnt   = 1'b0;
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // all three at once, bits 011 -> minority 0, mismatch
    set_round(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    run_round();
    // staggered, last vote lands exactly in the timeout cycle
    set_round(1, 1, 1, 0, 5, 3, 0, 1, 0, 2, 0);
    run_round();
    // only voter 1 votes -> timeout, votes 0,1,0
    set_round(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    run_round();
    // late voter arrives one cycle after the timeout cycle
    set_round(1, 0, 1, 1, 0, 1 + TIMEOUT + 1, 1, 0, 0, 0, 0);
    run_round();
    // back-pressure for 10 cycles with a straggler pushing during HOLD
    set_round(1, 1, 1, 2, 2, 2, 0, 0, 0, 10, 0);
    run_round();
    // saturation: five disagreeing rounds
    for (int r = 0; r < 5; r++) begin
      set_round(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      run_round();
    end
    // clear in the EVAL cycle of a mismatching round
    set_round(1, 1, 1, 0, 1, 0, 0, 1, 1, 1, 2);
    run_round();

    for (int r = 0; r < 150; r++) begin
      random_round();
      run_round();
    end

    reset_mid_collect();
    set_round(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    run_round();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mino_vote_ctrl.md
# mino_vote_ctrl

Sequencing controller for a 3-input minority vote. It collects one vote bit from each of three independent voters over per-voter valid/ready handshakes, waits a bounded number of cycles for stragglers, and evaluates minority = ~((a&b)|(b&c)|(c&a)). It presents the registered result on a valid/ready output port with a timeout flag and keeps a saturating count of rounds in which the voters disagreed. It sits between three redundant bit sources and a downstream consumer of the vote.

## Interface
- TIMEOUT, 15: cycles spent in COLLECT before missing votes are forced; legal range 1..255.
- CNT_W, 8: width of the disagreement counter.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- v_valid  input  3  voter i presents a vote (bit i = voter i)
- v_bit  input  3  vote values, sampled when v_valid[i] & v_ready[i]
- v_ready  output  3  controller accepts voter i this cycle
- res_valid  output  1  result available
- res_ready  input  1  consumer takes the result
- res_out  output  1  minority of the three latched votes
- res_timeout  output  1  at least one vote was forced by the timeout (qualified by res_valid)
- clr_cnt  input  1  synchronous clear of mismatch_cnt
- mismatch_cnt  output  CNT_W  saturating count of evaluated rounds whose received votes were not all equal

One clock; reset is asynchronous and active-low.

## Operation
- State machine: IDLE, COLLECT, EVAL, HOLD. Reset state is IDLE.
- Internal registers: vote[2:0], got[2:0], timer (8 bit), and a timeout flag.
- v_ready[i] = ~got[i] in IDLE and COLLECT, and 0 in EVAL and HOLD.
- IDLE: every accepted voter i sets got[i] and stores vote[i] = v_bit[i].
  - No accept: stay in IDLE.
  - Some accepts, but got is not 111 afterwards: go to COLLECT with timer = 0.
  - All three accepted in the same cycle: go to EVAL.
- COLLECT: accepts work as in IDLE, and timer increments each cycle.
  - got becomes 111: go to EVAL. This takes priority over the timeout.
  - Otherwise, when timer == TIMEOUT-1 in a cycle with got != 111: go to EVAL, set the timeout flag, and force each missing vote to 0.
  - An accept in the timeout cycle still counts.
- EVAL (1 cycle):
  - res_out <= ~((v0&v1)|(v1&v2)|(v2&v0)).
  - res_timeout <= the timeout flag.
  - mismatch_cnt increments, saturating at all-ones, when the received (non-forced) votes are not all equal. Fewer than two received votes is never a mismatch.
  - Then go to HOLD.
- HOLD: res_valid = 1, and res_out and res_timeout are stable. When res_ready is 1, go to IDLE and clear got, the timer and the timeout flag. Holding stalls all voters.
- clr_cnt takes priority over an increment in the same cycle.

## Timing
- Reset values: state IDLE, v_ready 3'b111, res_valid 0, res_out 0, res_timeout 0, mismatch_cnt 0, got 0, timer 0.
- Reset asserted mid-round discards all partial votes immediately. The pending result is lost and is not completed.
- Latency, all three votes accepted at cycle N in IDLE: EVAL at N+1, res_valid high from N+2.
- Latency, first vote at N and no further votes: COLLECT during N+1..N+TIMEOUT, EVAL at N+TIMEOUT+1, res_valid at N+TIMEOUT+2.
- res_valid is registered and drops the cycle after the handshake. New accepts are possible from the cycle after the HOLD exit, so back-to-back rounds cost at least 3 cycles.
- A voter already accepted in the current round sees v_ready[i] = 0 and is not re-sampled, even if v_valid[i] stays high.

## Test plan
- Reset, then v_valid = 111 and v_bit = 011 at cycle N → res_valid at N+2, res_out = 0, res_timeout = 0, mismatch_cnt = 1; res_ready held 1 → back in IDLE at N+3.
- Staggered votes: voter 0 = 0 at N, voter 2 = 0 at N+3, voter 1 = 1 at N+5 → v_ready = 110 then 010, res_out = 1, mismatch_cnt += 1.
- Timeout with TIMEOUT = 4: only voter 1 votes 1 at N → EVAL at N+5, res_out = 1 (votes 0,1,0), res_timeout = 1, mismatch_cnt unchanged.
- Back-pressure: result 1 held with res_ready = 0 for 10 cycles → res_valid and res_out stable, v_ready = 000; new v_valid is ignored until res_ready is asserted.
- Counter: CNT_W = 2, five disagreeing rounds → mismatch_cnt sticks at 3; clr_cnt asserted in an EVAL cycle with a mismatch → 0.
- rst_n pulsed low while in COLLECT with got = 101 → outputs return to reset values asynchronously; the next full round behaves as in the first scenario.
